// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: controller states and default operand width.
package div_pkg;

   localparam int unsigned DIV_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
module div_step #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH:0]   i_shifted,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0] w_diff;

   // The partial remainder stays below the divisor, so both the difference and
   // the restored value fit back into WIDTH bits.
   always_comb begin
      w_diff = i_shifted - {1'b0, i_divisor};
      o_qbit = ~w_diff[WIDTH];
      o_rem  = o_qbit ? w_diff[WIDTH-1:0] : i_shifted[WIDTH-1:0];
   end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, with start/busy/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (quotient truncates toward zero).
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned   CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   div_state_t       r_state, w_state_nxt;
   logic [WIDTH-1:0] r_rem, r_dvd, r_dvs;
   logic [CW-1:0]    r_cnt;
   logic             w_accept, w_dvs_zero, w_qbit;
   logic [WIDTH-1:0] w_rem_nxt, w_dvd_in, w_dvs_in, w_q_res, w_r_res;
   logic [WIDTH:0]   w_shift;

   assign w_dvs_zero = (divisor == '0);
   assign w_accept   = start && (r_state != RUN);
   assign busy       = (r_state == RUN);
   assign done       = (r_state == DONE);
   assign w_shift    = {r_rem, r_dvd[WIDTH-1]};

   div_step #(.WIDTH(WIDTH)) u_step (
      .i_shifted (w_shift),
      .i_divisor (r_dvs),
      .o_rem     (w_rem_nxt),
      .o_qbit    (w_qbit)
   );

`ifdef SEQ_DIVIDER_SIGNED_EN
   logic r_neg_q, r_neg_r;

   assign w_dvd_in = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_dvs_in = divisor[WIDTH-1]  ? -divisor  : divisor;
   assign w_q_res  = r_neg_q ? -{r_dvd[WIDTH-2:0], w_qbit} : {r_dvd[WIDTH-2:0], w_qbit};
   assign w_r_res  = r_neg_r ? -w_rem_nxt : w_rem_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
      end else if (w_accept) begin
         r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
         r_neg_r <= dividend[WIDTH-1];
      end
   end
`else
   assign w_dvd_in = dividend;
   assign w_dvs_in = divisor;
   assign w_q_res  = {r_dvd[WIDTH-2:0], w_qbit};
   assign w_r_res  = w_rem_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE:    if (start) w_state_nxt = w_dvs_zero ? DONE : RUN;
         RUN:     if (r_cnt == '0) w_state_nxt = DONE;
         DONE:    w_state_nxt = start ? (w_dvs_zero ? DONE : RUN) : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem       <= '0;
         r_dvd       <= '0;
         r_dvs       <= '0;
         r_cnt       <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (w_accept) begin
         r_rem <= '0;
         r_dvd <= w_dvd_in;
         r_dvs <= w_dvs_in;
         r_cnt <= CNT_LAST;
         // A zero divisor skips RUN, so its result is posted on the accept edge.
         if (w_dvs_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end else begin
            div_by_zero <= 1'b0;
         end
      end else if (r_state == RUN) begin
         r_rem <= w_rem_nxt;
         r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
         r_cnt <= r_cnt - CW'(1);
         if (r_cnt == '0) begin
            quotient  <= w_q_res;
            remainder <= w_r_res;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and random checks of seq_divider against a reference division model with a result scoreboard.
module tb_seq_divider;

   localparam int W = 4;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic         busy, done, div_by_zero;
   logic [W-1:0] quotient, remainder;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int   sa, sd;
      if (b == '0) begin
         e.q   = '1;
         e.r   = a;
         e.dbz = 1'b1;
      end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
         sa = int'($signed(a));
         sd = int'($signed(b));
`else
         sa = int'(a);
         sd = int'(b);
`endif
         e.q   = W'(sa / sd);
         e.r   = W'(sa % sd);
         e.dbz = 1'b0;
      end
      return e;
   endfunction

   // Drive a request (accepted on the next rising edge) and record its expected result.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      sb.push_back(model(a, b));
   endtask

   // Called on the falling edge after the accept; waits for done within a fixed budget.
   task automatic wait_done(input int exp_lat, input int exp_busy, input string tag);
      int           n = 0;
      int           nb = 0;
      logic [W-1:0] q0;
      q0 = quotient;
      while (done !== 1'b1 && n < 40) begin
         if (busy === 1'b1) nb++;
         if (n > 0) check({tag, "_q_hold"}, quotient, q0);
         @(negedge clk);
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_busy_cycles"}, nb, exp_busy);
      check({tag, "_busy_at_done"}, busy, 1'b0);
   endtask

   task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      @(negedge clk);
      issue(a, b);
      @(negedge clk);
      start = 1'b0;
      if (b == '0) wait_done(0, 0, tag);
      else         wait_done(W, W, tag);
   endtask

   // Scoreboard: every done pulse is matched against the oldest outstanding request.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_done", done, 1'b0);
         end else begin
            e = sb.pop_front();
            check("quotient", quotient, e.q);
            check("remainder", remainder, e.r);
            check("div_by_zero", div_by_zero, e.dbz);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_quotient", quotient, '0);
      check("rst_remainder", remainder, '0);
      check("rst_dbz", div_by_zero, 1'b0);
      rst_n = 1'b1;

      op(4'd13, 4'd3, "op13_3");
      op(4'd15, 4'd1, "op15_1");
      op(4'd2,  4'd9, "op2_9");
      op(4'd7,  4'd0, "op7_0");
      op(4'd6,  4'd3, "op6_3");

      // Start pulsed mid-RUN must be ignored, then start held in DONE is a back-to-back accept.
      @(negedge clk);
      issue(4'd12, 4'd5);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start    = 1'b1;
      dividend = 4'd3;
      divisor  = 4'd1;
      @(negedge clk);
      start = 1'b0;
      wait_done(W - 2, W - 2, "ignore_mid_run");
      issue(4'd14, 4'd4);
      @(negedge clk);
      start = 1'b0;
      wait_done(W, W, "back_to_back");

      // Asynchronous reset between edges while RUN is in progress.
      @(negedge clk);
      issue(4'd11, 4'd2);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      check("async_rst_busy", busy, 1'b0);
      check("async_rst_done", done, 1'b0);
      check("async_rst_quotient", quotient, '0);
      check("async_rst_remainder", remainder, '0);
      check("async_rst_dbz", div_by_zero, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      op(4'd9, 4'd2, "op9_2");

`ifdef SEQ_DIVIDER_SIGNED_EN
      op(4'b1001, 4'd2,    "s_m7_2");
      op(4'b1000, 4'b1111, "s_m8_m1");
      op(4'd7,    4'b1110, "s_7_m2");
      op(4'b1010, 4'd0,    "s_m6_0");
`endif

      for (int unsigned i = 0; i < 8; i++) begin
         op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), "random");
      end

      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
